// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Brief    : Accumulates COUNT adder sums per frame into a held, handshaked
//            total with a sticky wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
    parameter int IN_W  = 5,
    parameter int COUNT = 8,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    localparam int c_cnt_w = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(COUNT - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_ovf;
    logic                r_out_valid;
    logic [ACC_W-1:0]    r_out_acc;
    logic                r_out_ovf;

    logic                w_accept;
    logic [ACC_W:0]      w_sum;
    logic                w_ovf_next;

    // Extra top bit of the sum is the carry out of the accumulator.
    assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(in_sum);
    assign w_ovf_next = r_ovf | w_sum[ACC_W];
    assign in_ready   = !rst && !clr && (r_state == ST_ACCUM);
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clr) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_ovf <= w_ovf_next;
                        if (r_cnt == c_last) begin
                            r_cnt       <= '0;
                            r_out_acc   <= w_sum[ACC_W-1:0];
                            r_out_ovf   <= w_ovf_next;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Output registers keep the last total after the take.
                    if (r_out_valid && out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;
    assign busy      = (r_state == ST_ACCUM) && (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_accumulator
// Brief    : Table, directed and random checks of two sum_accumulator configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst, clr, in_valid, out_ready;
    logic [4:0] in_sum;

    logic       rdy0, val0, ovf0, busy0;
    logic [7:0] acc0;
    logic       rdy1, val1, ovf1, busy1;
    logic [5:0] acc1;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.IN_W(5), .COUNT(8), .ACC_W(8)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
        .in_sum(in_sum), .out_valid(val0), .out_ready(out_ready),
        .out_acc(acc0), .out_ovf(ovf0), .busy(busy0)
    );

    sum_accumulator #(.IN_W(5), .COUNT(4), .ACC_W(6)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .in_sum(in_sum), .out_valid(val1), .out_ready(out_ready),
        .out_acc(acc1), .out_ovf(ovf1), .busy(busy1)
    );

    // Frame-level reference: a frame is just a running integer total of its
    // samples; the reported total is that sum modulo 2^ACC_W and the wrap flag
    // is set exactly when the true total reaches 2^ACC_W.
    int   m_mod [2] = '{256, 64};
    int   m_cnt [2] = '{8, 4};
    bit   m_hold[2];
    int   m_n   [2];
    int   m_tot [2];
    int   m_oacc[2];
    bit   m_oovf[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_hold[k] = 0; m_n[k] = 0; m_tot[k] = 0; m_oacc[k] = 0; m_oovf[k] = 0;
            end else if (clr) begin
                m_hold[k] = 0; m_n[k] = 0; m_tot[k] = 0;
            end else if (m_hold[k]) begin
                if (out_ready) begin
                    m_hold[k] = 0; m_n[k] = 0; m_tot[k] = 0;
                end
            end else if (in_valid) begin
                m_tot[k] += int'(in_sum);
                m_n[k]++;
                if (m_n[k] == m_cnt[k]) begin
                    m_oacc[k] = m_tot[k] % m_mod[k];
                    m_oovf[k] = (m_tot[k] >= m_mod[k]);
                    m_hold[k] = 1;
                end
            end
        end
    endtask

    task automatic model_compare();
        bit er [2];
        bit eb [2];
        for (int k = 0; k < 2; k++) begin
            er[k] = !rst && !clr && !m_hold[k];
            eb[k] = !m_hold[k] && (m_n[k] != 0);
        end
        check("d0.out_valid", 32'(val0),  32'(m_hold[0]));
        check("d0.out_acc",   32'(acc0),  32'(m_oacc[0]));
        check("d0.out_ovf",   32'(ovf0),  32'(m_oovf[0]));
        check("d0.busy",      32'(busy0), 32'(eb[0]));
        check("d0.in_ready",  32'(rdy0),  32'(er[0]));
        check("d1.out_valid", 32'(val1),  32'(m_hold[1]));
        check("d1.out_acc",   32'(acc1),  32'(m_oacc[1]));
        check("d1.out_ovf",   32'(ovf1),  32'(m_oovf[1]));
        check("d1.busy",      32'(busy1), 32'(eb[1]));
        check("d1.in_ready",  32'(rdy1),  32'(er[1]));
    endtask

    task automatic drive(input logic r, input logic c, input logic v,
                         input logic [4:0] s, input logic o);
        rst = r; clr = c; in_valid = v; in_sum = s; out_ready = o;
    endtask

    task automatic half();
        @(negedge clk);
        model_compare();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input logic c, input logic v, input logic [4:0] s, input logic o);
        drive(1'b0, c, v, s, o);
        half();
        edge_step();
    endtask

    typedef struct {
        logic       rst, clr, v;
        logic [4:0] s;
        logic       ordy;
        logic       e_val;
        logic [7:0] e_acc;
        logic       e_ovf, e_busy, e_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic c, logic v, logic [4:0] s, logic o,
                                logic ev, logic [7:0] ea, logic eo, logic eb, logic er);
        vec_t t;
        t.rst = r; t.clr = c; t.v = v; t.s = s; t.ordy = o;
        t.e_val = ev; t.e_acc = ea; t.e_ovf = eo; t.e_busy = eb; t.e_rdy = er;
        return t;
    endfunction

    initial begin
        // reset held with in_valid=1, then one full frame of 30s, backpressure, take
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 1, 30, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 30, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 1, 30, 0, 0, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 30, 0, 1, 240, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 30, 1, 1, 240, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 240, 0, 0, 1));

        drive(1, 0, 1, 30, 0);
        edge_step();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].clr, tbl[i].v, tbl[i].s, tbl[i].ordy);
            half();
            check("tbl.out_valid", 32'(val0),  32'(tbl[i].e_val));
            check("tbl.out_acc",   32'(acc0),  32'(tbl[i].e_acc));
            check("tbl.out_ovf",   32'(ovf0),  32'(tbl[i].e_ovf));
            check("tbl.busy",      32'(busy0), 32'(tbl[i].e_busy));
            check("tbl.in_ready",  32'(rdy0),  32'(tbl[i].e_rdy));
            edge_step();
        end

        // gapped input 1..8
        step(1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 5'(i), 0);
            step(0, 0, 0, 0);
        end
        check("gap.out_valid", 32'(val0), 32'd1);
        check("gap.out_acc",   32'(acc0), 32'd36);
        check("gap.d1_acc",    32'(acc1), 32'd10);
        step(0, 0, 0, 1);

        // wrap with the narrow configuration
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 31, 0);
        check("ovf.out_valid", 32'(val1), 32'd1);
        check("ovf.out_acc",   32'(acc1), 32'd60);
        check("ovf.out_ovf",   32'(ovf1), 32'd1);
        step(0, 0, 0, 1);
        check("ovf.take_valid", 32'(val1), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
        check("ovf2.out_acc",  32'(acc1), 32'd4);
        check("ovf2.out_ovf",  32'(ovf1), 32'd0);

        // frame abort drops the sample presented with clr
        step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 10, 0);
        check("clr.busy_before", 32'(busy0), 32'd1);
        step(1, 1, 10, 0);
        check("clr.busy", 32'(busy0), 32'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 2, 0);
        check("clr.out_valid", 32'(val0), 32'd1);
        check("clr.out_acc",   32'(acc0), 32'd16);
        check("clr.d1_acc",    32'(acc1), 32'd8);

        // randomized traffic against the frame model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 200) == 0, ($urandom % 25) == 0, ($urandom % 10) < 7,
                  5'($urandom % 32), ($urandom % 10) < 4);
            half();
            edge_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
